// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, merged H/V counters and
// combinational region/sync/strobe decode of the registered state.
module vga_timing_gen #(
   parameter int CW       = 10,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CLK_DIV  = 2
) (
   input  logic          Clock,
   input  logic          Clear,
   input  logic          Enable,
   output logic [CW-1:0] HCount,
   output logic [CW-1:0] VCount,
   output logic [1:0]    HRegion,
   output logic [1:0]    VRegion,
   output logic          HSync,
   output logic          VSync,
   output logic          Active,
   output logic          PixelTick,
   output logic          LineEnd,
   output logic          FrameEnd
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] H_END   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_END   = CW'(V_TOTAL - 1);

   // Region boundaries kept 32-bit so a zero-width back porch cannot overflow CW.
   localparam int H_FP_START = H_ACTIVE;
   localparam int H_SY_START = H_ACTIVE + H_FP;
   localparam int H_BP_START = H_ACTIVE + H_FP + H_SYNC;
   localparam int V_FP_START = V_ACTIVE;
   localparam int V_SY_START = V_ACTIVE + V_FP;
   localparam int V_BP_START = V_ACTIVE + V_FP + V_SYNC;

   logic [DW-1:0] div;

   always_ff @(posedge Clock) begin
      if (Clear) begin
         div    <= '0;
         HCount <= '0;
         VCount <= '0;
      end else if (Enable) begin
         div <= (div == DIV_MAX) ? '0 : div + 1'b1;
         if (PixelTick) begin
            if (HCount == H_END) begin
               HCount <= '0;
               VCount <= (VCount == V_END) ? '0 : VCount + 1'b1;
            end else begin
               HCount <= HCount + 1'b1;
            end
         end
      end
   end

   always_comb begin
      if      (32'(HCount) < H_FP_START) HRegion = 2'd0;
      else if (32'(HCount) < H_SY_START) HRegion = 2'd1;
      else if (32'(HCount) < H_BP_START) HRegion = 2'd2;
      else                               HRegion = 2'd3;

      if      (32'(VCount) < V_FP_START) VRegion = 2'd0;
      else if (32'(VCount) < V_SY_START) VRegion = 2'd1;
      else if (32'(VCount) < V_BP_START) VRegion = 2'd2;
      else                               VRegion = 2'd3;
   end

   assign HSync     = (HRegion == 2'd2) ? HS_POL : ~HS_POL;
   assign VSync     = (VRegion == 2'd2) ? VS_POL : ~VS_POL;
   assign Active    = (HRegion == 2'd0) && (VRegion == 2'd0);
   assign PixelTick = Enable && (div == DIV_MAX);
   assign LineEnd   = PixelTick && (HCount == H_END);
   assign FrameEnd  = LineEnd && (VCount == V_END);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 geometry, a tiny
// CLK_DIV=1 positive-sync geometry, and a zero-width-porch geometry.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- default geometry ----------------
   logic d_clr = 1'b1, d_en = 1'b0;
   logic [9:0] d_hc, d_vc;
   logic [1:0] d_hr, d_vr;
   logic d_hs, d_vs, d_act, d_pt, d_le, d_fe;

   vga_timing_gen u_def (
      .Clock(clk), .Clear(d_clr), .Enable(d_en),
      .HCount(d_hc), .VCount(d_vc), .HRegion(d_hr), .VRegion(d_vr),
      .HSync(d_hs), .VSync(d_vs), .Active(d_act),
      .PixelTick(d_pt), .LineEnd(d_le), .FrameEnd(d_fe)
   );

   // ---------------- tiny geometry: H 8/2/3/1, V 4/1/1/1 ----------------
   logic s_clr = 1'b1, s_en = 1'b0;
   logic [9:0] s_hc, s_vc;
   logic [1:0] s_hr, s_vr;
   logic s_hs, s_vs, s_act, s_pt, s_le, s_fe;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)
   ) u_small (
      .Clock(clk), .Clear(s_clr), .Enable(s_en),
      .HCount(s_hc), .VCount(s_vc), .HRegion(s_hr), .VRegion(s_vr),
      .HSync(s_hs), .VSync(s_vs), .Active(s_act),
      .PixelTick(s_pt), .LineEnd(s_le), .FrameEnd(s_fe)
   );

   // ---------------- zero-width porches: H 4/0/2/0, V 2/0/1/0 ----------------
   logic z_clr = 1'b1, z_en = 1'b0;
   logic [9:0] z_hc, z_vc;
   logic [1:0] z_hr, z_vr;
   logic z_hs, z_vs, z_act, z_pt, z_le, z_fe;

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(0), .H_SYNC(2), .H_BP(0),
      .V_ACTIVE(2), .V_FP(0), .V_SYNC(1), .V_BP(0),
      .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(3)
   ) u_zero (
      .Clock(clk), .Clear(z_clr), .Enable(z_en),
      .HCount(z_hc), .VCount(z_vc), .HRegion(z_hr), .VRegion(z_vr),
      .HSync(z_hs), .VSync(z_vs), .Active(z_act),
      .PixelTick(z_pt), .LineEnd(z_le), .FrameEnd(z_fe)
   );

   // Reference state for the default instance
   int m_div = 0, m_h = 0, m_v = 0;

   function automatic int d_hreg(input int h);
      return (h < 640) ? 0 : (h < 656) ? 1 : (h < 752) ? 2 : 3;
   endfunction

   function automatic int d_vreg(input int v);
      return (v < 480) ? 0 : (v < 490) ? 1 : (v < 492) ? 2 : 3;
   endfunction

   task automatic d_step();
      logic pt, le;
      if (d_clr) begin
         m_div = 0; m_h = 0; m_v = 0;
      end else if (d_en) begin
         if (m_div == 1) begin
            m_div = 0;
            if (m_h == 799) begin
               m_h = 0;
               m_v = (m_v == 524) ? 0 : m_v + 1;
            end else m_h++;
         end else m_div = 1;
      end
      @(posedge clk); #1;
      pt = d_en && (m_div == 1);
      le = pt && (m_h == 799);
      chk("d_hcount",  d_hc,  m_h);
      chk("d_vcount",  d_vc,  m_v);
      chk("d_hregion", d_hr,  d_hreg(m_h));
      chk("d_vregion", d_vr,  d_vreg(m_v));
      chk("d_hsync",   d_hs,  (d_hreg(m_h) == 2) ? 0 : 1);
      chk("d_vsync",   d_vs,  (d_vreg(m_v) == 2) ? 0 : 1);
      chk("d_active",  d_act, (m_h < 640 && m_v < 480) ? 1 : 0);
      chk("d_tick",    d_pt,  pt);
      chk("d_lineend", d_le,  le);
      chk("d_frameend",d_fe,  le && (m_v == 524));
   endtask

   int s_h = 0, s_v = 0;

   task automatic s_step();
      if (s_clr) begin
         s_h = 0; s_v = 0;
      end else if (s_en) begin
         if (s_h == 13) begin
            s_h = 0;
            s_v = (s_v == 6) ? 0 : s_v + 1;
         end else s_h++;
      end
      @(posedge clk); #1;
      chk("s_hcount",  s_hc, s_h);
      chk("s_vcount",  s_vc, s_v);
      chk("s_hregion", s_hr, (s_h < 8) ? 0 : (s_h < 10) ? 1 : (s_h < 13) ? 2 : 3);
      chk("s_hsync",   s_hs, (s_h >= 10 && s_h <= 12) ? 1 : 0);
      chk("s_vsync",   s_vs, (s_v == 5) ? 1 : 0);
      chk("s_tick",    s_pt, s_en);
      chk("s_frameend",s_fe, (s_en && s_h == 13 && s_v == 6) ? 1 : 0);
   endtask

   initial begin
      int cnt, le_cnt, fe_cnt, hs_lo, vs_hi;
      logic [3:0] hmask, vmask;

      // Reset state with Enable low
      d_step();
      chk("d_rst_hsync", d_hs, 1);
      chk("d_rst_active", d_act, 1);
      chk("d_rst_tick", d_pt, 0);

      // Release: pixel advances every second clock
      d_clr = 1'b0; d_en = 1'b1;
      d_step();
      chk("d_first_hold", d_hc, 0);
      d_step();
      chk("d_first_adv", d_hc, 1);

      // Freeze on the last divider phase of pixel 100
      for (int i = 0; i < 400 && !(m_h == 100 && m_div == 1); i++) d_step();
      chk("d_at100", d_hc, 100);
      d_en = 1'b0; #1;
      chk("d_freeze_tick", d_pt, 0);
      for (int i = 0; i < 50; i++) d_step();
      d_en = 1'b1; #1;
      chk("d_resume_tick", d_pt, 1);
      d_step();
      chk("d_resume_101", d_hc, 101);

      // Clear mid-line
      for (int i = 0; i < 2000 && m_h != 700; i++) d_step();
      d_clr = 1'b1;
      d_step();
      chk("d_clr_h", d_hc, 0);
      chk("d_clr_v", d_vc, 0);
      chk("d_clr_vsync", d_vs, 1);
      chk("d_clr_le", d_le, 0);
      d_clr = 1'b0;

      // Line wrap and LineEnd period
      cnt = 0;
      while (cnt < 2000 && !d_le) begin d_step(); cnt++; end
      chk("d_le_seen", d_le, 1);
      d_step();
      chk("d_wrap_h", d_hc, 0);
      chk("d_wrap_v", d_vc, 1);
      cnt = 1;
      while (cnt < 2000 && !d_le) begin d_step(); cnt++; end
      chk("d_le_period", cnt, 1600);

      // Clear coincident with a line wrap: VCount must not advance
      for (int i = 0; i < 2000 && !(m_h == 799 && m_div == 1); i++) d_step();
      chk("d_wrap_le", d_le, 1);
      d_clr = 1'b1;
      d_step();
      chk("d_clrwrap_v", d_vc, 0);
      d_clr = 1'b0; d_en = 1'b0;

      // Tiny geometry: two frames
      s_step();
      s_clr = 1'b0; s_en = 1'b1;
      fe_cnt = 0; le_cnt = 0;
      for (int i = 0; i < 196; i++) begin
         s_step();
         if (s_fe) fe_cnt++;
         if (s_le) le_cnt++;
      end
      chk("s_fe_count", fe_cnt, 2);
      chk("s_le_count", le_cnt, 14);
      cnt = 0;
      while (cnt < 200 && !s_fe) begin s_step(); cnt++; end
      s_step(); cnt = 1;
      while (cnt < 200 && !s_fe) begin s_step(); cnt++; end
      chk("s_fe_period", cnt, 98);

      // Clear wins over the frame wrap
      chk("s_pre_fe", s_fe, 1);
      s_clr = 1'b1;
      s_step();
      chk("s_clr_h", s_hc, 0);
      chk("s_clr_v", s_vc, 0);
      s_clr = 1'b0;
      cnt = 0;
      while (cnt < 200 && !s_fe) begin s_step(); cnt++; end
      chk("s_fe_after_clr", cnt, 97);
      s_en = 1'b0;

      // Zero-width porches: regions 1 and 3 never appear
      @(posedge clk); #1;
      z_clr = 1'b0; z_en = 1'b1;
      hmask = '0; vmask = '0; fe_cnt = 0; hs_lo = 0; vs_hi = 0;
      for (int i = 0; i < 108; i++) begin
         @(posedge clk); #1;
         hmask[z_hr] = 1'b1;
         vmask[z_vr] = 1'b1;
         if (z_fe) fe_cnt++;
         if (!z_hs) hs_lo++;
         if (z_vs) vs_hi++;
      end
      chk("z_hmask", hmask, 4'b0101);
      chk("z_vmask", vmask, 4'b0101);
      chk("z_fe_count", fe_cnt, 2);
      chk("z_hsync_low", hs_lo, 36);
      chk("z_vsync_high", vs_hi, 36);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. It merges the horizontal and vertical counters into one block.
- Each axis has a configurable porch/sync geometry and sync polarity.
- An internal pixel-clock-enable divider lets the block run from the system clock.
- Outputs: pixel coordinates, per-axis region codes, sync/active signals, and line/frame strobes for the pixel pipeline and frame buffer reader.

Parameters:
- CW, 10, width of HCount/VCount; must hold max(H_TOTAL, V_TOTAL)-1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- HS_POL, 0, HSync asserted level (0 = active-low).
- VS_POL, 0, VSync asserted level.
- CLK_DIV, 2, Clock cycles per pixel (>=1).

Ports:
- Clock, input, 1, system clock; all state updates on rising edge.
- Clear, input, 1, reset, synchronous and active-high.
- Enable, input, 1, run enable; low freezes divider and counters.
- HCount, output, CW, current pixel column, 0..H_TOTAL-1.
- VCount, output, CW, current line, 0..V_TOTAL-1.
- HRegion, output, 2, 0 active / 1 front porch / 2 sync / 3 back porch.
- VRegion, output, 2, same encoding for the vertical axis.
- HSync, output, 1, horizontal sync, polarity per HS_POL.
- VSync, output, 1, vertical sync, polarity per VS_POL.
- Active, output, 1, high when HRegion==0 and VRegion==0.
- PixelTick, output, 1, one-cycle strobe when the counters advance at the next edge.
- LineEnd, output, 1, PixelTick && HCount==H_TOTAL-1.
- FrameEnd, output, 1, LineEnd && VCount==V_TOTAL-1.

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Registered state: divider Div (0..CLK_DIV-1), HCount, VCount. Every other output is a combinational decode of the registered state plus Enable.
- Clear (priority over everything): at the next edge Div=0, HCount=0, VCount=0. The decoded outputs then read:
  - HRegion=VRegion=0, Active=1.
  - HSync=~HS_POL, VSync=~VS_POL.
  - LineEnd=FrameEnd=0.
  - PixelTick=(Enable && CLK_DIV==1).
- Clear asserted mid-line or mid-frame gives the same result: no partial-line flush, no strobe emitted.
- PixelTick = Enable && Div==CLK_DIV-1.
- Div: when Enable is high it increments each clock and wraps to 0 after CLK_DIV-1. When Enable is low it holds.
- On PixelTick:
  - HCount increments; at H_TOTAL-1 it wraps to 0 and VCount increments.
  - VCount wraps to 0 at V_TOTAL-1 when HCount also wraps.
- Counters never change without PixelTick.
- H decode on HCount:
  - [0, H_ACTIVE) = 0.
  - [H_ACTIVE, H_ACTIVE+H_FP) = 1.
  - [.., +H_SYNC) = 2.
  - rest = 3.
- V decode on VCount: the same scheme using the V parameters.
- HSync = HS_POL when HRegion==2, else ~HS_POL. VSync is the same using VRegion and VS_POL.
- Sync and region outputs change in the same cycle as the counter that drives them; there is zero latency from counter to decode.
- LineEnd and FrameEnd are single-cycle and coincide with the PixelTick that causes the wrap. FrameEnd implies LineEnd.
- Enable dropped mid-line: all state freezes and PixelTick, LineEnd and FrameEnd stay 0. Resuming continues from the held Div value with no skipped or repeated pixel.
- Zero-width porch parameters (e.g. H_BP=0) are legal; that region code never appears. H_SYNC and V_SYNC must be >=1.

Test Plan:
- Defaults, Clear 1 cycle then Enable=1:
  - HCount advances every 2 clocks.
  - HCount 640..655 -> HRegion=1, Active=0.
  - HCount 656..751 -> HSync=0, HRegion=2.
  - HCount 752..799 -> HRegion=3.
  - After 799, HCount wraps to 0 and VCount=1. LineEnd pulses once per 1600 clocks.
- Defaults, full frame:
  - VCount 490..491 -> VSync=0.
  - 480..489 -> VRegion=1.
  - 492..524 -> VRegion=3.
  - FrameEnd pulses exactly once every 840000 clocks, coincident with LineEnd.
  - VCount wraps 524->0.
- Enable low for 50 clocks at HCount=100 -> HCount, VCount and Div unchanged, PixelTick=0 throughout. After re-enable, HCount reaches 101 within 2 clocks.
- Clear asserted at HCount=700, VCount=300 -> next edge HCount=0, VCount=0, HSync=VSync=1, Active=1, no LineEnd/FrameEnd.
- Override CLK_DIV=1, HS_POL=1, VS_POL=1, H 8/2/3/1, V 4/1/1/1 (H_TOTAL=14, V_TOTAL=7):
  - HSync=1 at HCount 10..12.
  - VSync=1 at VCount 5.
  - PixelTick constant 1.
  - FrameEnd every 98 clocks.
- Simultaneous Clear and Enable at HCount=H_TOTAL-1 with Div=CLK_DIV-1 -> Clear wins: counters go to 0,0, VCount is not incremented, and the frame count observed via FrameEnd is unchanged.
